// File: rtl/sb_pkg.sv
// Shared types and the byte-lane merge helper for the store buffer.
// Entry field widths track the default ADDR_W/DATA_W of store_buffer_gen.
package sb_pkg;

    localparam int SB_ADDR_W  = 32;
    localparam int SB_DATA_W  = 32;
    localparam int SB_BE_W    = SB_DATA_W / 8;
    localparam int SB_OFF_W   = $clog2(SB_BE_W);
    localparam int SB_WADDR_W = SB_ADDR_W - SB_OFF_W;

    // Entries keep only the word address; the byte offset is implied zero.
    typedef struct packed {
        logic                  valid;
        logic [SB_WADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0]  data;
        logic [SB_BE_W-1:0]    be;
    } sb_entry_t;

    typedef struct packed {
        logic [SB_DATA_W-1:0] data;
        logic [SB_BE_W-1:0]   be;
    } sb_merge_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_DRAIN,
        SB_FLUSH
    } sb_state_t;

    function automatic sb_merge_t be_merge(
        input logic [SB_DATA_W-1:0] old_data,
        input logic [SB_BE_W-1:0]   old_be,
        input logic [SB_DATA_W-1:0] new_data,
        input logic [SB_BE_W-1:0]   new_be
    );
        sb_merge_t m;
        m.be = old_be | new_be;
        for (int i = 0; i < SB_BE_W; i++) begin
            m.data[8*i +: 8] = new_be[i] ? new_data[8*i +: 8]
                                         : old_data[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Youngest-first byte merge across all valid entries matching a word address.
// Also reports the index of the youngest matching entry.
module sb_fwd_merge
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  sb_entry_t                i_mem [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] i_head,
    input  logic [SB_WADDR_W-1:0]    i_waddr,
    output logic [SB_DATA_W-1:0]     o_data,
    output logic [SB_BE_W-1:0]       o_be,
    output logic                     o_hit,
    output logic [$clog2(DEPTH)-1:0] o_idx
);

    localparam int IW = $clog2(DEPTH);

    sb_merge_t     w_acc;
    logic [IW-1:0] w_idx;

    // Walk oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        w_acc = '0;
        w_idx = '0;
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + IW'(k);
            if (i_mem[w_idx].valid && (i_mem[w_idx].addr == i_waddr)) begin
                w_acc = be_merge(w_acc.data, w_acc.be,
                                 i_mem[w_idx].data, i_mem[w_idx].be);
                o_hit = 1'b1;
                o_idx = w_idx;
            end
        end
    end

    assign o_data = w_acc.data;
    assign o_be   = w_acc.be;

endmodule

// File: rtl/store_buffer_gen.sv
// Parametrised MEM-stage store buffer: in-order drain, forwarding, flush.
// Define SB_COALESCE_EN to merge stores into the youngest matching entry.
module store_buffer_gen
    import sb_pkg::*;
#(
    parameter int  DEPTH        = 4,
    parameter int  ADDR_W       = SB_ADDR_W,
    parameter int  DATA_W       = SB_DATA_W,
    parameter int  DRAIN_THRESH = 2,
    localparam int BE_W         = DATA_W / 8,
    localparam int CW           = $clog2(DEPTH) + 1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [BE_W-1:0]   st_be,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BE_W-1:0]   ld_be,
    output logic              fwd_hit,
    output logic              fwd_partial,
    output logic [DATA_W-1:0] fwd_data,
    input  logic              cache_idle,
    output logic              drain_valid,
    input  logic              drain_ready,
    output logic [ADDR_W-1:0] drain_addr,
    output logic [DATA_W-1:0] drain_data,
    output logic [BE_W-1:0]   drain_be,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    localparam int IW  = $clog2(DEPTH);
    localparam int OFF = $clog2(BE_W);

    sb_entry_t             r_mem [DEPTH];
    logic [CW-1:0]         r_head;
    logic [CW-1:0]         r_tail;
    sb_state_t             r_state;
    sb_state_t             w_state_nxt;
    logic                  r_pend;
    logic                  w_pend_nxt;
    logic [IW-1:0]         w_hidx;
    logic [IW-1:0]         w_tidx;
    logic [CW-1:0]         w_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_enq;
    logic                  w_alloc;
    logic                  w_deq;
    logic                  w_merge_ok;
    logic                  w_drain_go;
    logic                  w_drain_keep;
    logic [SB_WADDR_W-1:0] w_st_waddr;
    logic [SB_WADDR_W-1:0] w_ld_waddr;
    logic [SB_DATA_W-1:0]  w_fdata;
    logic [SB_BE_W-1:0]    w_fbe;
    logic                  w_fhit;
    logic [IW-1:0]         w_fidx;
    logic [BE_W-1:0]       w_cov;
    logic [DATA_W-1:0]     w_lane_mask;
    logic                  w_unused;

    assign w_hidx     = r_head[IW-1:0];
    assign w_tidx     = r_tail[IW-1:0];
    assign w_cnt      = r_tail - r_head;
    assign count      = w_cnt;
    assign empty      = (w_cnt == '0);
    assign full       = (w_cnt == CW'(DEPTH));
    assign w_st_waddr = st_addr[ADDR_W-1:OFF];
    assign w_ld_waddr = ld_addr[ADDR_W-1:OFF];
    assign w_unused   = ^{st_addr[OFF-1:0], ld_addr[OFF-1:0], w_fhit, w_fidx};

`ifdef SB_COALESCE_EN
    logic [IW-1:0]        w_yidx;
    logic [SB_DATA_W-1:0] w_cdata;
    logic [SB_BE_W-1:0]   w_cbe;
    logic                 w_chit;
    logic [IW-1:0]        w_cidx;
    sb_merge_t            w_mrg;
    logic                 w_unused_coal;

    assign w_yidx = w_tidx - IW'(1);

    sb_fwd_merge #(.DEPTH(DEPTH)) u_coal (
        .i_mem   (r_mem),
        .i_head  (w_hidx),
        .i_waddr (w_st_waddr),
        .o_data  (w_cdata),
        .o_be    (w_cbe),
        .o_hit   (w_chit),
        .o_idx   (w_cidx)
    );

    // Only the youngest entry may absorb a store, never a head being drained.
    assign w_merge_ok = !empty && w_chit && (w_cidx == w_yidx)
                        && !(drain_valid && (w_yidx == w_hidx));
    assign w_mrg = be_merge(r_mem[w_yidx].data, r_mem[w_yidx].be,
                            st_data, st_be);
    assign w_unused_coal = ^{w_cdata, w_cbe};
`else
    assign w_merge_ok = 1'b0;
`endif

    assign st_ready    = (!full || w_merge_ok) && (r_state != SB_FLUSH);
    assign w_enq       = st_valid && st_ready && (st_be != '0);
    assign w_alloc     = w_enq && !w_merge_ok;
    assign drain_valid = ((r_state == SB_DRAIN) || (r_state == SB_FLUSH))
                         && !empty;
    assign w_deq       = drain_valid && drain_ready;
    assign w_cnt_nxt   = w_cnt + CW'(w_alloc) - CW'(w_deq);

    assign w_drain_go   = !empty
                          && ((w_cnt >= CW'(DRAIN_THRESH)) || cache_idle);
    assign w_drain_keep = (w_cnt_nxt != '0)
                          && ((w_cnt_nxt >= CW'(DRAIN_THRESH)) || cache_idle);

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend | flush_req;
        flush_done  = 1'b0;
        unique case (r_state)
            SB_IDLE: begin
                if (w_pend_nxt) begin
                    w_state_nxt = SB_FLUSH;
                    w_pend_nxt  = 1'b0;
                end else if (w_drain_go) begin
                    w_state_nxt = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                // A flush request waits for the in-flight handshake.
                if (w_deq) begin
                    if (w_pend_nxt) begin
                        w_state_nxt = SB_FLUSH;
                        w_pend_nxt  = 1'b0;
                    end else if (!w_drain_keep) begin
                        w_state_nxt = SB_IDLE;
                    end
                end
            end
            SB_FLUSH: begin
                w_pend_nxt = 1'b0;
                if (empty) begin
                    flush_done  = 1'b1;
                    w_state_nxt = SB_IDLE;
                end
            end
            default: begin
                w_state_nxt = SB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_state <= SB_IDLE;
            r_pend  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_deq) begin
                r_mem[w_hidx].valid <= 1'b0;
                r_head              <= r_head + CW'(1);
            end
            if (w_alloc) begin
                r_mem[w_tidx] <= '{valid: 1'b1, addr: w_st_waddr,
                                   data: st_data, be: st_be};
                r_tail        <= r_tail + CW'(1);
            end
`ifdef SB_COALESCE_EN
            if (w_enq && w_merge_ok) begin
                r_mem[w_yidx].data <= w_mrg.data;
                r_mem[w_yidx].be   <= w_mrg.be;
            end
`endif
        end
    end

    assign drain_addr = {r_mem[w_hidx].addr, {OFF{1'b0}}};
    assign drain_data = r_mem[w_hidx].data;
    assign drain_be   = r_mem[w_hidx].be;

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
        .i_mem   (r_mem),
        .i_head  (w_hidx),
        .i_waddr (w_ld_waddr),
        .o_data  (w_fdata),
        .o_be    (w_fbe),
        .o_hit   (w_fhit),
        .o_idx   (w_fidx)
    );

    assign w_cov = w_fbe & ld_be & {BE_W{ld_valid}};

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            w_lane_mask[8*i +: 8] = {8{w_cov[i]}};
        end
    end

    assign fwd_hit     = ld_valid && (w_cov == ld_be);
    assign fwd_partial = ld_valid && (w_cov != '0) && !fwd_hit;
    assign fwd_data    = w_fdata & w_lane_mask;

endmodule

// File: tb/tb_store_buffer_gen.sv
// Directed bench for store_buffer_gen with drain and forwarding scoreboards.
// Expected drains and lookups are queued at issue and checked by a monitor.
module tb_store_buffer_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_be;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        fwd_hit, fwd_partial;
    logic [31:0] fwd_data;
    logic        cache_idle;
    logic        drain_valid, drain_ready;
    logic [31:0] drain_addr, drain_data;
    logic [3:0]  drain_be;
    logic        flush_req, flush_done;
    logic        empty, full;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer_gen dut (
        .clock       (clk),
        .reset       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_be       (st_be),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_be       (ld_be),
        .fwd_hit     (fwd_hit),
        .fwd_partial (fwd_partial),
        .fwd_data    (fwd_data),
        .cache_idle  (cache_idle),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_addr  (drain_addr),
        .drain_data  (drain_data),
        .drain_be    (drain_be),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } dexp_t;

    typedef struct {
        logic        hit;
        logic        part;
        logic [31:0] data;
    } fexp_t;

    dexp_t dq[$];
    fexp_t fq[$];
    dexp_t de;
    fexp_t fe;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ndone;
    bit    sr_bad;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_drain(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        dq.push_back('{addr: a, data: d, be: b});
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = b;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] b,
                           input logic h, input logic p,
                           input logic [31:0] d);
        fq.push_back('{hit: h, part: p, data: d});
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_be    = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic drain_all();
        drain_ready = 1'b1;
        cache_idle  = 1'b1;
        for (int i = 0; i < 20 && !empty; i++) tick();
        chk("drain_all_empty", empty, 1);
        drain_ready = 1'b0;
        cache_idle  = 1'b0;
    endtask

    // Monitor: checks drains and lookups that happen at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && drain_valid && drain_ready) begin
            if (dq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_unexpected: got addr %0h, required none",
                         drain_addr);
            end else begin
                de = dq.pop_front();
                chk("drain_addr", drain_addr, de.addr);
                chk("drain_data", drain_data, de.data);
                chk("drain_be", drain_be, de.be);
            end
        end
        if (rst_n && ld_valid) begin
            if (fq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fwd_unexpected: got lookup, required none");
            end else begin
                fe = fq.pop_front();
                chk("fwd_hit", fwd_hit, fe.hit);
                chk("fwd_partial", fwd_partial, fe.part);
                chk("fwd_data", fwd_data, fe.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
        cache_idle = 1'b0; drain_ready = 1'b0; flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_drain_valid", drain_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_count", count, 0);
        chk("rst_fwd", {fwd_hit, fwd_partial, fwd_data}, 0);
        rst_n = 1'b1;

        // Reset with three entries held; contents are lost.
        do_store(32'h100, 32'h1, 4'hf);
        do_store(32'h104, 32'h2, 4'hf);
        do_store(32'h108, 32'h3, 4'hf);
        chk("fill3_count", count, 3);
        rst_n = 1'b0;
        #1;
        chk("areset_count", count, 0);
        chk("areset_drain_valid", drain_valid, 0);
        tick();
        rst_n = 1'b1;
        chk("post_rst_empty", empty, 1);
        chk("post_rst_drain_valid", drain_valid, 0);
        chk("post_rst_st_ready", st_ready, 1);
        chk("post_rst_fwd_hit", fwd_hit, 0);
        do_load(32'h100, 4'hf, 1'b0, 1'b0, 32'h0);

        // Store and same-cycle lookup: not yet visible.
        fq.push_back('{hit: 1'b0, part: 1'b0, data: 32'h0});
        ld_valid = 1'b1; ld_addr = 32'h4; ld_be = 4'hf;
        exp_drain(32'h4, 32'hA, 4'hf);
        do_store(32'h4, 32'hA, 4'hf);
        ld_valid = 1'b0;
        do_load(32'h4, 4'hf, 1'b1, 1'b0, 32'h0000000A);
        chk("below_thresh_no_drain", drain_valid, 0);
        chk("one_entry_count", count, 1);

        // Byte-lane merge across two stores to the same word.
        do_store(32'h8, 32'h11, 4'b0001);
        do_store(32'h8, 32'h2200, 4'b0010);
`ifdef SB_COALESCE_EN
        exp_drain(32'h8, 32'h2211, 4'b0011);
`else
        exp_drain(32'h8, 32'h11, 4'b0001);
        exp_drain(32'h8, 32'h2200, 4'b0010);
`endif
        do_load(32'h8, 4'b0011, 1'b1, 1'b0, 32'h2211);
        do_load(32'hA, 4'b1111, 1'b0, 1'b1, 32'h2211);
        drain_all();

        // Fill to full with the cache stalled.
        for (int i = 0; i < 4; i++) begin
            exp_drain(32'h20 + 4 * i, 32'hC0 + i, 4'hf);
            do_store(32'h20 + 4 * i, 32'hC0 + i, 4'hf);
        end
        chk("full_flag", full, 1);
        chk("full_st_ready", st_ready, 0);
        chk("full_count", count, 4);
        chk("full_drain_valid", drain_valid, 1);
        chk("stall_addr0", drain_addr, 32'h20);
        chk("stall_data0", drain_data, 32'hC0);
        tick();
        chk("stall_addr1", drain_addr, 32'h20);
        chk("stall_data1", drain_data, 32'hC0);

        // One handshake while a store waits; head still forwards.
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'hC4; st_be = 4'hf;
        exp_drain(32'h30, 32'hC4, 4'hf);
        drain_ready = 1'b1;
        fq.push_back('{hit: 1'b1, part: 1'b0, data: 32'hC0});
        ld_valid = 1'b1; ld_addr = 32'h20; ld_be = 4'hf;
        tick();
        ld_valid = 1'b0;
        drain_ready = 1'b0;
        chk("no_bypass_count", count, 3);
        chk("no_bypass_st_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        chk("late_enq_count", count, 4);

        // Flush with three entries left.
        drain_ready = 1'b1;
        tick();
        drain_ready = 1'b0;
        chk("pre_flush_count", count, 3);
        flush_req = 1'b1;
        drain_ready = 1'b1;
        tick();
        flush_req = 1'b0;
        ndone = 0;
        sr_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ndone == 0 && st_ready) sr_bad = 1'b1;
            if (flush_done) ndone++;
            tick();
        end
        drain_ready = 1'b0;
        chk("flush_done_pulses", ndone, 1);
        chk("flush_st_ready_low", sr_bad, 0);
        chk("flush_empty", empty, 1);

        // Flush on an empty buffer.
        flush_req = 1'b1;
        #1;
        chk("eflush_done_now", flush_done, 0);
        tick();
        flush_req = 1'b0;
        chk("eflush_done_next", flush_done, 1);
        chk("eflush_st_ready", st_ready, 0);
        tick();
        chk("eflush_done_once", flush_done, 0);
        chk("eflush_st_ready_back", st_ready, 1);

        // Two half-word stores to one word.
        do_store(32'h10, 32'h0000BBAA, 4'b0011);
        do_store(32'h10, 32'hDDCC0000, 4'b1100);
`ifdef SB_COALESCE_EN
        chk("coal_count", count, 1);
        exp_drain(32'h10, 32'hDDCCBBAA, 4'b1111);
`else
        chk("coal_count", count, 2);
        exp_drain(32'h10, 32'h0000BBAA, 4'b0011);
        exp_drain(32'h10, 32'hDDCC0000, 4'b1100);
`endif
        do_load(32'h10, 4'hf, 1'b1, 1'b0, 32'hDDCCBBAA);
        drain_all();

        // A zero byte-enable store is dropped.
        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h55; st_be = 4'h0;
        #1;
        chk("be0_st_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        chk("be0_count", count, 0);

        repeat (3) tick();
        chk("drain_queue_left", dq.size(), 0);
        chk("fwd_queue_left", fq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
